inverter_pipe: RTL

Parametrised, pipelined successor to the 32-bit combinational inverter. Applies a per-word selectable bit operation (pass, invert, masked invert, bit-reverse-invert) to a WIDTH-bit stream. Data moves through a STAGES-deep register pipeline under valid/ready flow control. Sits between a streaming source and sink in the datapath, and counts completed output transfers for status readout.

---
 rtl/inverter_pkg.sv | 48 ++++
 rtl/inverter_stage.sv | 28 ++
 rtl/inverter_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter pipeline.
//   mode_t  : per-word bit operation selector
//   MODE_W  : width of the mode field
//   OP_W    : widest word bit_op can handle (callers zero-extend into it)
//   bit_op  : result word for a given data/mode/mask, reversal taken over
//             the low 'width' bits only
package inverter_pkg;

  localparam int MODE_W = 2;
  localparam int OP_W   = 256;
  localparam int OP_IW  = $clog2(OP_W);

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_MASKED = 2'd2,
    MODE_REVINV = 2'd3
  } mode_t;

  function automatic logic [OP_W-1:0] bit_op(
    input logic [OP_W-1:0] data,
    input mode_t           mode,
    input logic [OP_W-1:0] mask,
    input int unsigned     width
  );
    logic [OP_W-1:0]  r;
    logic [OP_IW-1:0] idx;
    r   = '0;
    idx = '0;
    case (mode)
      MODE_PASS:   r = data;
      MODE_INVERT: r = ~data;
      MODE_MASKED: r = data ^ mask;
      MODE_REVINV: begin
        // Mirror within the live word width, not within OP_W.
        for (int i = 0; i < OP_W; i++) begin
          if (i < width) begin
            idx  = OP_IW'(width - 1 - i);
            r[i] = ~data[idx];
          end
        end
      end
      default:     r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inverter_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit data register.
//   clk, rst_n       : clock, asynchronous active-low reset
//   adv              : shift enable; slot holds when low
//   d_valid, d_data  : value loaded on an advancing edge
//   q_valid, q_data  : registered slot contents
module inverter_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (adv) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/inverter_pipe.sv
// Pipelined, mode-selectable bit inverter with valid/ready flow control.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  : input stream; in_mode and in_mask travel
//                                with in_data
//   out_valid/out_ready/out_data : output stream
//   cnt_clr                    : synchronous clear of xfer_cnt (wins over
//                                a same-cycle count)
//   xfer_cnt                   : completed output handshakes, wrapping
// WIDTH must not exceed inverter_pkg::OP_W.
module inverter_pipe
  import inverter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [WIDTH-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Whole pipeline moves in lockstep: it shifts whenever the last slot is
  // empty or being drained, bubbles included.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [OP_W-1:0] data_ext;
  logic [OP_W-1:0] mask_ext;
  logic [OP_W-1:0] res_ext;

  always_comb begin
    data_ext             = '0;
    mask_ext             = '0;
    data_ext[WIDTH-1:0]  = in_data;
    mask_ext[WIDTH-1:0]  = in_mask;
  end

  assign res_ext = bit_op(data_ext, mode_t'(in_mode), mask_ext, WIDTH);

  // Bits above WIDTH are always zero-extension residue.
  logic unused_res;
  assign unused_res = &{1'b0, res_ext};

  // Chain index 0 is the combinational result at acceptance; index s+1 is
  // the output of stage s.
  logic [STAGES:0]  vld_p;
  logic [WIDTH-1:0] data_p [STAGES+1];

  assign vld_p[0]  = in_valid;
  assign data_p[0] = res_ext[WIDTH-1:0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // stage s -> stage s+1
    inverter_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .d_valid (vld_p[s]),
      .d_data  (data_p[s]),
      .q_valid (vld_p[s+1]),
      .q_data  (data_p[s+1])
    );
  end

  assign out_valid = vld_p[STAGES];
  assign out_data  = data_p[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule
